// File: rtl/dmi_chain_pkg.sv
// Shared types for the JTAG DMI chain: op codes, captured status codes and request FSM states.
package dmi_chain_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        STATUS_OK     = 2'd0,
        STATUS_FAILED = 2'd2,
        STATUS_BUSY   = 2'd3
    } dmi_status_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP
    } dmi_state_e;

    function automatic logic more_than_one(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// Parallel-load / serial-shift register behind the DR chain; shifts toward bit 0, LSB out first.
module jtag_shift_reg #(
    parameter int L = 41
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic         serial_in,
    input  logic [L-1:0] load_value,
    output logic [L-1:0] value,
    output logic         serial_out
);

    logic [L-1:0] sr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_value;
        end else if (shift) begin
            sr <= {serial_in, sr[L-1:1]};
        end
    end

    assign value      = sr;
    assign serial_out = sr[0];

endmodule

// File: rtl/jtag_dmi_chain_ctrl.sv
// JTAG DMI access chain: decodes TAP strobes, issues one DMI request per accepted update,
// buffers the last response and keeps sticky busy/error status for the debugger to poll.
module jtag_dmi_chain_ctrl
    import dmi_chain_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int OP_W   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              chain_shift,
    input  logic              chain_capture,
    input  logic              chain_update,
    input  logic              chain_data_in,
    output logic              chain_data_out,
    output logic              chain_error,
    input  logic              dmi_reset,
    input  logic              dmi_hard_reset,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_data,
    output logic [OP_W-1:0]   req_op,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic [OP_W-1:0]   rsp_resp,
    output logic              sticky_busy,
    output logic              sticky_err
);

    localparam int L = OP_W + DATA_W + ADDR_W;

    dmi_state_e state, next_state;

    logic [L-1:0]      sr_value;
    logic [L-1:0]      capture_value;
    logic [OP_W-1:0]   sr_op;
    logic [DATA_W-1:0] sr_data;
    logic [ADDR_W-1:0] sr_addr;
    logic [OP_W-1:0]   status;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] rsp_buf;

    logic do_capture, do_update, do_shift;
    logic op_ok, update_accept, busy_event, rsp_take;

    // Capture beats update beats shift; the loser strobes are simply ignored.
    assign do_capture = chain_capture;
    assign do_update  = chain_update & ~chain_capture;
    assign do_shift   = chain_shift & ~chain_capture & ~chain_update;

    assign sr_op   = sr_value[OP_W-1:0];
    assign sr_data = sr_value[OP_W +: DATA_W];
    assign sr_addr = sr_value[OP_W+DATA_W +: ADDR_W];

    always_comb begin
        status = OP_W'(STATUS_OK);
        if (sticky_busy || state != ST_IDLE) begin
            status = OP_W'(STATUS_BUSY);
        end else if (sticky_err) begin
            status = OP_W'(STATUS_FAILED);
        end
    end

    assign capture_value = {last_addr, rsp_buf, status};

    jtag_shift_reg #(.L(L)) u_shift_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (do_capture),
        .shift      (do_shift),
        .serial_in  (chain_data_in),
        .load_value (capture_value),
        .value      (sr_value),
        .serial_out (chain_data_out)
    );

    assign op_ok = (sr_op == OP_W'(OP_READ)) || (sr_op == OP_W'(OP_WRITE));
    assign update_accept = do_update && state == ST_IDLE && !sticky_busy && !sticky_err
                           && op_ok && !dmi_hard_reset;
    assign busy_event = (do_capture || do_update) && state != ST_IDLE;
    assign rsp_take   = state == ST_WAIT_RSP && rsp_valid && !dmi_hard_reset;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (update_accept) next_state = ST_REQ;
            end
            ST_REQ: begin
                req_valid = 1'b1;
                if (req_ready) next_state = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                rsp_ready = 1'b1;
                if (rsp_valid) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        if (dmi_hard_reset) next_state = ST_IDLE;
    end

    // Flag clears take precedence over a same-edge set.
    always_ff @(posedge clock) begin
        if (!reset) begin
            req_addr    <= '0;
            req_data    <= '0;
            req_op      <= '0;
            last_addr   <= '0;
            rsp_buf     <= '0;
            sticky_busy <= 1'b0;
            sticky_err  <= 1'b0;
            chain_error <= 1'b0;
        end else begin
            chain_error <= more_than_one(chain_capture, chain_update, chain_shift);
            if (update_accept) begin
                req_addr  <= sr_addr;
                req_data  <= sr_data;
                req_op    <= sr_op;
                last_addr <= sr_addr;
            end
            if (rsp_take) begin
                rsp_buf <= rsp_data;
            end
            if (dmi_reset || dmi_hard_reset) begin
                sticky_busy <= 1'b0;
                sticky_err  <= 1'b0;
            end else begin
                if (busy_event) sticky_busy <= 1'b1;
                if (rsp_take && rsp_resp != '0) sticky_err <= 1'b1;
            end
        end
    end

endmodule
